// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: synchroniser, debounce FSM and
// press / auto-repeat / continuous pulse generation per button.
module btn_channel #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int MCEN_DELAY      = 50_000_000,
  parameter int MCEN_PERIOD     = 10_000_000,
  parameter int CCEN_PERIOD     = 10_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button,
  output logic dpb,
  output logic scen,
  output logic mcen,
  output logic ccen
);
  localparam int DW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int CW  = (CCEN_PERIOD > 1) ? $clog2(CCEN_PERIOD) : 1;
  localparam int MDW = (MCEN_DELAY > 1) ? $clog2(MCEN_DELAY) : 1;
  localparam int MPW = (MCEN_PERIOD > 1) ? $clog2(MCEN_PERIOD) : 1;
  localparam int MW  = (MDW > MPW) ? MDW : MPW;

  typedef enum logic [1:0] {IDLE, CONFIRM_PRESS, HELD, CONFIRM_RELEASE} state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  state_t                 state, state_nxt;
  logic [DW-1:0]          cnt, cnt_nxt;
  logic [CW-1:0]          ccnt, ccnt_nxt;
  logic [MW-1:0]          mcnt, mcnt_nxt;
  logic                   mph, mph_nxt;   // 0: waiting out the initial delay, 1: periodic
  logic                   dpb_q, dpb_nxt, sc_q, sc_nxt, mc_q, mc_nxt, cc_q, cc_nxt;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync <= '0;
    else          sync <= {sync[SYNC_STAGES-2:0], button};
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ccnt_nxt  = ccnt;
    mcnt_nxt  = mcnt;
    mph_nxt   = mph;
    dpb_nxt   = dpb_q;
    sc_nxt    = 1'b0;
    mc_nxt    = 1'b0;
    cc_nxt    = 1'b0;
    case (state)
      IDLE: if (s) begin
        state_nxt = CONFIRM_PRESS;
        cnt_nxt   = '0;
      end
      CONFIRM_PRESS: begin
        if (!s) state_nxt = IDLE;
        else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          state_nxt = HELD;
          dpb_nxt   = 1'b1;
          sc_nxt    = 1'b1;
          mc_nxt    = 1'b1;
          cc_nxt    = 1'b1;
          ccnt_nxt  = '0;
          mcnt_nxt  = '0;
          mph_nxt   = 1'b0;
        end else cnt_nxt = cnt + DW'(1);
      end
      HELD: begin
        if (!s) begin
          state_nxt = CONFIRM_RELEASE;
          cnt_nxt   = '0;
        end
        // every cycle spent in HELD advances the hold time, including the exit cycle
        if (ccnt == CW'(CCEN_PERIOD - 1)) begin
          ccnt_nxt = '0;
          cc_nxt   = 1'b1;
        end else ccnt_nxt = ccnt + CW'(1);
        if (!mph) begin
          if (mcnt == MW'(MCEN_DELAY - 1)) begin
            mcnt_nxt = '0;
            mph_nxt  = 1'b1;
            mc_nxt   = 1'b1;
          end else mcnt_nxt = mcnt + MW'(1);
        end else begin
          if (mcnt == MW'(MCEN_PERIOD - 1)) begin
            mcnt_nxt = '0;
            mc_nxt   = 1'b1;
          end else mcnt_nxt = mcnt + MW'(1);
        end
      end
      CONFIRM_RELEASE: begin
        if (s) state_nxt = HELD;
        else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          state_nxt = IDLE;
          dpb_nxt   = 1'b0;
        end else cnt_nxt = cnt + DW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      ccnt  <= '0;
      mcnt  <= '0;
      mph   <= 1'b0;
      dpb_q <= 1'b0;
      sc_q  <= 1'b0;
      mc_q  <= 1'b0;
      cc_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ccnt  <= ccnt_nxt;
      mcnt  <= mcnt_nxt;
      mph   <= mph_nxt;
      dpb_q <= dpb_nxt;
      sc_q  <= sc_nxt;
      mc_q  <= mc_nxt;
      cc_q  <= cc_nxt;
    end
  end

  // Output stage: acceptance lands SYNC_STAGES+DEBOUNCE_CYCLES+1 edges after the input edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dpb  <= 1'b0;
      scen <= 1'b0;
      mcen <= 1'b0;
      ccen <= 1'b0;
    end else begin
      dpb  <= dpb_q;
      scen <= sc_q;
      mcen <= mc_q;
      ccen <= cc_q;
    end
  end
endmodule

module button_conditioner #(
  parameter int NUM_BTNS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int MCEN_DELAY      = 50_000_000,
  parameter int MCEN_PERIOD     = 10_000_000,
  parameter int CCEN_PERIOD     = 10_000_000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_BTNS-1:0] buttons,
  output logic [NUM_BTNS-1:0] DPBs,
  output logic [NUM_BTNS-1:0] SCENs,
  output logic [NUM_BTNS-1:0] MCENs,
  output logic [NUM_BTNS-1:0] CCENs
);
  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    btn_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .MCEN_DELAY     (MCEN_DELAY),
      .MCEN_PERIOD    (MCEN_PERIOD),
      .CCEN_PERIOD    (CCEN_PERIOD)
    ) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .button (buttons[i]),
      .dpb    (DPBs[i]),
      .scen   (SCENs[i]),
      .mcen   (MCENs[i]),
      .ccen   (CCENs[i])
    );
  end
endmodule

// File: doc/button_conditioner.md
# button_conditioner

Parametrised push-button conditioning block for the maze game's input path; the successor to the fixed four-button input interface. It takes `NUM_BTNS` raw, asynchronous button levels (up/down/left/right and any added buttons) and produces four per-button outputs: debounced level, single-clock press pulse, auto-repeat pulse and continuous pulse. These feed game logic and menu handling. Every channel is an independent copy of the same synchroniser, debounce FSM and repeat timers.

## Interface
- `NUM_BTNS`, 4: number of button channels.
- `SYNC_STAGES`, 2: synchroniser depth per channel; must be ≥2.
- `DEBOUNCE_CYCLES`, 1_000_000: number of stable synchronised cycles needed to accept a press or a release; must be ≥1.
- `MCEN_DELAY`, 50_000_000: cycles from press acceptance to the first auto-repeat pulse; must be ≥1.
- `MCEN_PERIOD`, 10_000_000: cycles between later auto-repeat pulses; must be ≥1.
- `CCEN_PERIOD`, 10_000_000: cycles between continuous pulses while held; must be ≥1.

- `clk`  in  1: single clock; every register in the block uses this clock.
- `reset_n`  in  1: asynchronous reset, active-low.
- `buttons`  in  NUM_BTNS: raw button levels, asynchronous to `clk`, 1 = pressed.
- `DPBs`  out  NUM_BTNS: debounced button level.
- `SCENs`  out  NUM_BTNS: one-cycle pulse when a press is accepted.
- `MCENs`  out  NUM_BTNS: auto-repeat pulse; fires once on press, then repeats after the hold delay.
- `CCENs`  out  NUM_BTNS: continuous pulse; fires on press, then every `CCEN_PERIOD` cycles.

## Operation
- Synchroniser: `buttons[i]` passes through `SYNC_STAGES` flops. The last flop is `s[i]`.
- Per-channel FSM states: IDLE, CONFIRM_PRESS, HELD, CONFIRM_RELEASE.
  - IDLE: if `s`=1, go to CONFIRM_PRESS and set `cnt`=0.
  - CONFIRM_PRESS:
    - If `s`=0, return to IDLE.
    - Else if `cnt`==DEBOUNCE_CYCLES-1, go to HELD. On this transition `DPBs[i]`←1, pulse SCEN/MCEN/CCEN, and clear the repeat counters.
    - Else `cnt`++.
  - HELD:
    - If `s`=0, go to CONFIRM_RELEASE and set `cnt`=0.
    - Otherwise the repeat counters run.
  - CONFIRM_RELEASE:
    - If `s`=1, return to HELD with no SCEN. Repeat counters resume from their frozen values.
    - Else if `cnt`==DEBOUNCE_CYCLES-1, go to IDLE and set `DPBs[i]`←0.
    - Else `cnt`++.
- Repeat counters run only in HELD and are frozen in CONFIRM_RELEASE. Hold time h counts cycles spent in HELD, with h=0 at the acceptance edge.
  - CCEN fires at h = k·CCEN_PERIOD, k≥0.
  - MCEN fires at h=0, h=MCEN_DELAY and h=MCEN_DELAY+k·MCEN_PERIOD.
  - Implement with wrapping counters, never a free-running h. Counter widths are `$clog2` of each parameter, with no overflow for any hold duration.
- A button already held when reset releases is treated as a fresh press.
- Channels are fully independent. Simultaneous events on different channels do not interact.

## Timing
- All outputs are registered. Reset value of every output, FSM state, counter and synchroniser flop is 0 / IDLE. Reset takes effect immediately, including mid-debounce or mid-hold.
- Press latency: if `buttons[i]` rises before edge 0 and stays high, the acceptance edge is edge SYNC_STAGES+DEBOUNCE_CYCLES+1. `DPBs` rises there, and SCEN/MCEN/CCEN pulse high for exactly that one cycle.
- Release latency: also SYNC_STAGES+DEBOUNCE_CYCLES+1 edges after a clean fall.
- SCEN pulses exactly once per accepted press. Every pulse output is high for exactly one cycle and never for two consecutive cycles, except when the period parameter equals 1.
- Glitch rejection: any high excursion of `s` shorter than DEBOUNCE_CYCLES cycles produces no output. The same holds for low excursions during a hold.

## Test plan
Bench parameters: NUM_BTNS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, MCEN_DELAY=10, MCEN_PERIOD=3, CCEN_PERIOD=5.
- Clean press: `buttons`=4'b0001 from edge 0 → `DPBs[0]` rises at edge 7. SCENs/MCENs/CCENs[0] are each high for one cycle at edge 7 only. Other channels stay 0.
- Bounce rejection: `buttons[1]` high for 3 cycles, then low → all channel-1 outputs stay 0 throughout.
- Long hold, 30 cycles past acceptance → CCEN at h=0,5,10,15,20,25. MCEN at h=0,10,13,16,19,22,25,28. SCEN only at h=0.
- Release: clean fall → `DPBs` falls 7 edges later. A 2-cycle low glitch mid-hold → `DPBs` stays 1, no SCEN, and the repeat phase is shifted only by the frozen cycles.
- Independence and reset: press ch2 and ch3 with a 2-cycle offset → all outputs are identical but offset by 2 cycles. Assert `reset_n`=0 at h=12 → every output drops to 0 asynchronously. While `reset_n` is asserted, all outputs stay 0 even with the buttons held. With the buttons still held, releasing `reset_n` gives re-acceptance 7 edges after release.
